// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers
//   CLK, RST                        clock, synchronous active-high reset
//   req_valid, req_data, req_ready  per-requester valid/ready byte handshake (req_ready one-hot, combinational)
//   tx_busy                         registered busy flag from the transmitter
//   tx_data, tx_valid               registered byte and one-cycle Data_Valid pulse to the transmitter
//   grant_id                        requester owning the current frame
//   active                          frame in progress (ISSUE through WAIT_DONE)
//   timeout_err                     one-cycle pulse when the transmitter never raised busy
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          tx_busy,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          active,
    output logic                          timeout_err
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d, grant_q, grant_d, win, idx;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d, err_q, err_d, found, grant, limit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NUM_REQ - 1);
            grant_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Scan from ptr+NUM_REQ down to ptr+1 so the nearest valid requester after ptr is written last.
    // The modulo keeps the wrap correct when NUM_REQ is not a power of two.
    always_comb begin
        win   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grant   = state_q == IDLE && !tx_busy && found;
        limit   = cnt_q == CW'(BUSY_TIMEOUT - 1);
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE:      state_d = grant ? ISSUE : IDLE;
            ISSUE: begin
                state_d = WAIT_BUSY;
                cnt_d   = '0;
            end
            WAIT_BUSY: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = tx_busy ? WAIT_DONE : limit ? IDLE : WAIT_BUSY;
                err_d   = !tx_busy && limit;
            end
            default:   state_d = tx_busy ? WAIT_DONE : IDLE;
        endcase
        valid_d = grant;
        ptr_d   = grant ? win : ptr_q;
        grant_d = grant ? win : grant_q;
        data_d  = grant ? req_data[win*DATA_WIDTH +: DATA_WIDTH] : data_q;
    end

    always_comb begin
        req_ready   = grant ? NUM_REQ'(1) << win : '0;
        tx_data     = data_q;
        tx_valid    = valid_q;
        grant_id    = grant_q;
        active      = state_q != IDLE;
        timeout_err = err_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;
    int          n_pass = 0;
    int          n_total = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BUSY_TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_valid(tx_valid), .grant_id(grant_id),
        .active(active), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        req_valid = '0;
        tx_busy = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Waits (bounded) for a grant, captures the handshake and the ISSUE-cycle outputs, then plays a
    // transmitter that raises busy two cycles after tx_valid and holds it for 'hold' cycles.
    // Returns in the IDLE cycle following the frame.
    task automatic serve(input int hold, output logic [3:0] rdy, output logic [7:0] dat,
                         output logic [1:0] gid, output logic vld);
        rdy = '0;
        for (int i = 0; i < 30 && rdy == 4'b0; i++) begin
            #1;
            if (req_ready != 4'b0) rdy = req_ready;
            else tick();
        end
        tick();
        vld = tx_valid;
        dat = tx_data;
        gid = grant_id;
        tick();
        tick();
        tx_busy = 1'b1;
        repeat (hold) tick();
        tx_busy = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else n_pass++;
        n_total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else n_pass++;
        n_total++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id); else n_pass++;
        n_total++; if (active !== 1'b0) $display("FAIL reset_active: got %b want 0", active); else n_pass++;
        n_total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else n_pass++;
        n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else n_pass++;
    endtask

    task automatic test_single();
        int errs = 0;
        req_data = {8'h13, 8'h12, 8'h11, 8'hA5};
        req_valid = 4'b0001;
        #1;
        n_total++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready); else n_pass++;
        tick();
        req_valid = 4'b0000;
        n_total++; if (tx_valid !== 1'b1) $display("FAIL single_tx_valid: got %b want 1", tx_valid); else n_pass++;
        n_total++; if (tx_data !== 8'hA5) $display("FAIL single_tx_data: got %h want a5", tx_data); else n_pass++;
        n_total++; if (grant_id !== 2'd0) $display("FAIL single_grant_id: got %0d want 0", grant_id); else n_pass++;
        n_total++; if (active !== 1'b1) $display("FAIL single_active_issue: got %b want 1", active); else n_pass++;
        n_total++; if (req_ready !== 4'b0000) $display("FAIL single_ready_issue: got %b want 0000", req_ready); else n_pass++;
        tick();
        n_total++; if (tx_valid !== 1'b0) $display("FAIL single_valid_pulse: got %b want 0", tx_valid); else n_pass++;
        tick();
        tx_busy = 1'b1;
        repeat (11) begin
            tick();
            if (timeout_err) errs++;
        end
        tx_busy = 1'b0;
        #1;
        n_total++; if (active !== 1'b1) $display("FAIL single_active_busy_fall: got %b want 1", active); else n_pass++;
        tick();
        n_total++; if (active !== 1'b0) $display("FAIL single_active_after: got %b want 0", active); else n_pass++;
        n_total++; if (tx_data !== 8'hA5) $display("FAIL single_data_hold: got %h want a5", tx_data); else n_pass++;
        n_total++; if (errs != 0 || timeout_err !== 1'b0) $display("FAIL single_no_timeout: got %0d pulses want 0", errs); else n_pass++;
    endtask

    task automatic test_contention();
        logic [3:0] rdy;
        logic [7:0] dat;
        logic [1:0] gid;
        logic       vld;
        logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            serve(3, rdy, dat, gid, vld);
            n_total++; if (rdy !== 4'b0001 << exp_g[f]) $display("FAIL cont_ready[%0d]: got %b want %b", f, rdy, 4'b0001 << exp_g[f]); else n_pass++;
            n_total++; if (gid !== exp_g[f]) $display("FAIL cont_grant[%0d]: got %0d want %0d", f, gid, exp_g[f]); else n_pass++;
            n_total++; if (dat !== 8'h10 + 8'(exp_g[f])) $display("FAIL cont_data[%0d]: got %h want %h", f, dat, 8'h10 + 8'(exp_g[f])); else n_pass++;
            n_total++; if (vld !== 1'b1) $display("FAIL cont_valid[%0d]: got %b want 1", f, vld); else n_pass++;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_wrap();
        logic [3:0] rdy;
        logic [7:0] dat;
        logic [1:0] gid;
        logic       vld;
        do_reset();
        req_valid = 4'b0100;
        serve(2, rdy, dat, gid, vld);
        n_total++; if (gid !== 2'd2) $display("FAIL wrap_first: got %0d want 2", gid); else n_pass++;
        req_valid = 4'b0011;
        serve(2, rdy, dat, gid, vld);
        n_total++; if (gid !== 2'd0 || dat !== 8'h10) $display("FAIL wrap_second: got %0d/%h want 0/10", gid, dat); else n_pass++;
        serve(2, rdy, dat, gid, vld);
        n_total++; if (gid !== 2'd1 || dat !== 8'h11) $display("FAIL wrap_third: got %0d/%h want 1/11", gid, dat); else n_pass++;
        req_valid = 4'b0000;
    endtask

    task automatic test_timeout();
        int first = 0;
        int pulses = 0;
        logic act8 = 1'b0;
        logic act9 = 1'b1;
        logic [3:0] rdy;
        logic [7:0] dat;
        logic [1:0] gid;
        logic       vld;
        req_valid = 4'b0010;
        #1;
        n_total++; if (req_ready !== 4'b0010) $display("FAIL to_ready: got %b want 0010", req_ready); else n_pass++;
        tick();
        req_valid = 4'b0000;
        n_total++; if (tx_valid !== 1'b1 || tx_data !== 8'h11) $display("FAIL to_issue: got %b/%h want 1/11", tx_valid, tx_data); else n_pass++;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (timeout_err) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (k == 8) act8 = active;
            if (k == 9) act9 = active;
        end
        n_total++; if (first != 9) $display("FAIL to_pulse_cycle: got %0d want 9", first); else n_pass++;
        n_total++; if (pulses != 1) $display("FAIL to_pulse_count: got %0d want 1", pulses); else n_pass++;
        n_total++; if (act8 !== 1'b1 || act9 !== 1'b0) $display("FAIL to_active: got %b%b want 10", act8, act9); else n_pass++;
        req_valid = 4'b0001;
        serve(2, rdy, dat, gid, vld);
        n_total++; if (rdy !== 4'b0001 || gid !== 2'd0 || dat !== 8'h10) $display("FAIL to_recover: got %b/%0d/%h want 0001/0/10", rdy, gid, dat); else n_pass++;
        req_valid = 4'b0000;
    endtask

    task automatic test_busy_block();
        int leaks = 0;
        logic [3:0] rdy;
        logic [7:0] dat;
        logic [1:0] gid;
        logic       vld;
        tx_busy = 1'b1;
        req_valid = 4'b0100;
        repeat (4) begin
            #1;
            if (req_ready !== 4'b0000) leaks++;
            tick();
        end
        n_total++; if (leaks != 0 || active !== 1'b0) $display("FAIL busy_block: got %0d grants want 0", leaks); else n_pass++;
        tx_busy = 1'b0;
        #1;
        n_total++; if (req_ready !== 4'b0100) $display("FAIL busy_release_ready: got %b want 0100", req_ready); else n_pass++;
        serve(2, rdy, dat, gid, vld);
        n_total++; if (gid !== 2'd2 || dat !== 8'h12) $display("FAIL busy_release_grant: got %0d/%h want 2/12", gid, dat); else n_pass++;
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b1000;
        #1;
        n_total++; if (req_ready !== 4'b1000) $display("FAIL mid_ready: got %b want 1000", req_ready); else n_pass++;
        tick();
        req_valid = 4'b0000;
        tick();
        tx_busy = 1'b1;
        tick();
        n_total++; if (active !== 1'b1 || grant_id !== 2'd3) $display("FAIL mid_wait_done: got %b/%0d want 1/3", active, grant_id); else n_pass++;
        RST = 1'b1;
        tx_busy = 1'b0;
        tick();
        RST = 1'b0;
        n_total++; if ({tx_valid, tx_data, grant_id, active, timeout_err} !== 12'h000) $display("FAIL mid_outputs: got %b/%h/%0d/%b/%b want all 0", tx_valid, tx_data, grant_id, active, timeout_err); else n_pass++;
        req_valid = 4'b1111;
        #1;
        n_total++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b want 0001", req_ready); else n_pass++;
        tick();
        req_valid = 4'b0000;
        n_total++; if (grant_id !== 2'd0 || tx_data !== 8'h10 || tx_valid !== 1'b1) $display("FAIL mid_issue: got %0d/%h/%b want 0/10/1", grant_id, tx_data, tx_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_timeout();
        test_busy_block();
        test_reset_mid();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter (tx_fsm plus serializer/parity/mux datapath) between NUM_REQ byte producers.
- Accepts one byte per grant using a valid/ready handshake, presents it to the transmitter with a single-cycle Data_Valid pulse, then tracks the transmitter's busy flag until the frame completes.
- Recovers with an error pulse if the transmitter never acknowledges.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, byte width presented to the transmitter
- BUSY_TIMEOUT, 8, cycles allowed in WAIT_BUSY for tx_busy to rise (must be ≥3)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte available
- req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot accept strobe, combinational
- tx_busy  in  1  registered busy output of the UART transmitter
- tx_data  out  DATA_WIDTH  byte to transmitter (P_DATA), registered
- tx_valid  out  1  Data_Valid pulse to transmitter, registered
- grant_id  out  $clog2(NUM_REQ)  index of the requester owning the current frame
- active  out  1  high from ISSUE through end of WAIT_DONE
- timeout_err  out  1  one-cycle pulse on WAIT_BUSY timeout

Behaviour:
- Reset (RST=1 at a clock edge):
  - state=IDLE; tx_data=0, tx_valid=0, grant_id=0, active=0, timeout_err=0, timeout counter=0.
  - RR pointer=NUM_REQ-1, so the first search starts at requester 0.
  - Reset mid-frame aborts the arbiter only. The transmitter is not reset by this block.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If tx_busy=0 and any req_valid=1, the winner is the first set req_valid searching ptr+1, ptr+2, … modulo NUM_REQ.
  - req_ready[winner]=1 in the same cycle; the handshake completes that cycle.
  - On the edge: tx_data<=winner's req_data, grant_id<=winner, ptr<=winner, state<=ISSUE.
  - If tx_busy=1, no grant is made and req_ready=0.
  - req_ready is 0 in all other states.
- ISSUE:
  - tx_valid=1 for exactly this one cycle; state<=WAIT_BUSY; counter cleared to 0.
- WAIT_BUSY:
  - tx_busy=1 → WAIT_DONE.
  - Otherwise the counter increments. When counter==BUSY_TIMEOUT-1 with tx_busy=0 → IDLE, with timeout_err=1 for one cycle (registered, visible the cycle after the transition edge).
  - If tx_busy rises in the same cycle the counter hits its limit, the busy path wins and no error is raised.
- WAIT_DONE:
  - tx_busy=0 → IDLE.
  - Next grant is possible in the IDLE cycle immediately following.
- Timing and throughput:
  - Nominal transmitter response: busy rises 2 cycles after the tx_valid cycle.
  - Minimum arbiter overhead per frame is 1 IDLE cycle plus 1 ISSUE cycle.
- Stability:
  - tx_data and grant_id hold from the grant edge until the next grant. Requesters may change req_data after their handshake.
- Requester behaviour while not granted:
  - Deasserting req_valid without a handshake is permitted; that requester is simply skipped.
- Fairness:
  - The pointer advances only on a grant; a timeout still consumes that requester's turn.
  - With all requesters continuously valid, the grant order is 0,1,…,NUM_REQ-1,0,…
- Width rule:
  - Pointer and grant_id arithmetic wrap modulo NUM_REQ (not modulo 2^width when NUM_REQ is not a power of 2).
- active: 1 in ISSUE, WAIT_BUSY and WAIT_DONE; 0 in IDLE.

Test Plan:
- Single request:
  - Stimulus: req_valid=0001, req_data[0]=0xA5; transmitter model raises busy 2 cycles after tx_valid and holds it 11 cycles.
  - Required: req_ready=0001 for 1 cycle; tx_valid 1 cycle later with tx_data=0xA5, grant_id=0; active falls the cycle after busy falls; no timeout_err.
- Full contention:
  - Stimulus: req_valid=1111 held for 5 frames, bytes 0x10/0x11/0x12/0x13.
  - Required: grants in order 0,1,2,3,0; tx_data sequence 0x10,0x11,0x12,0x13,0x10.
- Sparse round-robin wrap, NUM_REQ=4:
  - Stimulus: after a grant to 2, req_valid=0011.
  - Required: next grant=0 (3 skipped, wrap); then 1.
- Timeout:
  - Stimulus: tx_busy tied 0, one request.
  - Required: tx_valid pulse, then after BUSY_TIMEOUT=8 WAIT_BUSY cycles a single timeout_err pulse; return to IDLE; next request is granted normally.
- Busy blocks grant:
  - Stimulus: tx_busy=1 in IDLE with req_valid=0100.
  - Required: req_ready stays 0; grant to 2 occurs in the first cycle tx_busy=0.
- Reset mid-frame:
  - Stimulus: RST=1 for 1 cycle during WAIT_DONE.
  - Required: next cycle all outputs 0 and state IDLE; with req_valid=1111 the first grant is 0.
